// File: rtl/snake_pkg.sv
// Shared types and defaults for the snake direction front-end.
// Contents: dir_t direction encoding, opposite() helper, default debounce length.
// No logic; imported by the interface, the debouncer and the top.
package snake_pkg;

  typedef enum logic [1:0] {
    UP    = 2'd0,
    DOWN  = 2'd1,
    LEFT  = 2'd2,
    RIGHT = 2'd3
  } dir_t;

  localparam int DEF_DEBOUNCE_CYCLES = 16;

  // The encoding pairs opposites in bit 0, so flipping it gives the reversal.
  function automatic dir_t opposite(input dir_t d);
    return dir_t'(d ^ 2'b01);
  endfunction

endpackage

// File: rtl/snake_dir_ctrl_if.sv
// Bus between the game core / button pins and snake_dir_ctrl.
// slave: DUT side (buttons and listen in; dir, dir_upd, q_count, drop out).
// master: environment side, mirror directions.
interface snake_dir_ctrl_if #(
  parameter int QUEUE_DEPTH = 4
);
  import snake_pkg::*;

  logic                               up;
  logic                               down;
  logic                               left;
  logic                               right;
  logic                               listen;
  dir_t                               dir;
  logic                               dir_upd;
  logic [$clog2(QUEUE_DEPTH+1)-1:0]   q_count;
  logic                               drop;

  modport slave (
    input  up, down, left, right, listen,
    output dir, dir_upd, q_count, drop
  );

  modport master (
    output up, down, left, right, listen,
    input  dir, dir_upd, q_count, drop
  );

endinterface

// File: rtl/snake_debounce.sv
// Single-button debouncer: level flips after DEBOUNCE_CYCLES consecutive cycles of disagreement.
// Latency: raw change to stable flip = DEBOUNCE_CYCLES cycles; rise pulse is registered with the flip.
// Ports: clk, rst (async active-low), raw in; stable level and 1-cycle rise pulse out. No backpressure.
module snake_debounce
  import snake_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES
) (
  input  logic clk,
  input  logic rst,
  input  logic raw,
  output logic stable,
  output logic rise
);

  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);

  logic [CW-1:0] cnt_q, cnt_d;
  logic          stable_q, stable_d;
  logic          rise_q, rise_d;

  always_comb begin
    cnt_d    = cnt_q;
    stable_d = stable_q;
    rise_d   = 1'b0;
    if (raw == stable_q) begin
      cnt_d = '0;
    end else if (cnt_q == CW'(DEBOUNCE_CYCLES - 1)) begin
      // This cycle is the DEBOUNCE_CYCLES-th disagreeing one: commit the new level.
      cnt_d    = '0;
      stable_d = raw;
      rise_d   = raw;
    end else begin
      cnt_d = cnt_q + CW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_q    <= '0;
      stable_q <= 1'b0;
      rise_q   <= 1'b0;
    end else begin
      cnt_q    <= cnt_d;
      stable_q <= stable_d;
      rise_q   <= rise_d;
    end
  end

  assign stable = stable_q;
  assign rise   = rise_q;

endmodule

// File: rtl/snake_dir_ctrl.sv
// Direction front-end: debounce 4 buttons, filter duplicate/reversal presses, queue, release on listen.
// Latency: press edge enqueues 1 cycle after the debounced flip; pop updates dir at the listen edge.
// Ports: clk, rst (async active-low), bus (slave). Full FIFO discards presses with a drop pulse.
// Option SNAKE_DIR_SYNC_EN adds a 2-flop synchroniser per button (2 extra cycles of input latency).
module snake_dir_ctrl
  import snake_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
  parameter int QUEUE_DEPTH     = 4,
  parameter int RESET_DIR       = 3
) (
  input  logic            clk,
  input  logic            rst,
  snake_dir_ctrl_if.slave bus
);

  localparam int CW = $clog2(QUEUE_DEPTH + 1);
  localparam int PW = (QUEUE_DEPTH > 1) ? $clog2(QUEUE_DEPTH) : 1;
  localparam logic [PW-1:0] LAST = PW'(QUEUE_DEPTH - 1);

  // Bit order is the priority order: [3]=up, [2]=down, [1]=left, [0]=right.
  logic [3:0] raw;
  logic [3:0] raw_s;
  logic [3:0] stable_lvl;
  logic [3:0] rise;
  logic       unused_stable;

  assign raw = {bus.up, bus.down, bus.left, bus.right};

`ifdef SNAKE_DIR_SYNC_EN
  logic [3:0] sync1_q, sync1_d, sync2_q, sync2_d;

  always_comb begin
    sync1_d = raw;
    sync2_d = sync1_q;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync1_q <= '0;
      sync2_q <= '0;
    end else begin
      sync1_q <= sync1_d;
      sync2_q <= sync2_d;
    end
  end

  assign raw_s = sync2_q;
`else
  assign raw_s = raw;
`endif

  for (genvar i = 0; i < 4; i++) begin : g_db
    snake_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db (
      .clk    (clk),
      .rst    (rst),
      .raw    (raw_s[i]),
      .stable (stable_lvl[i]),
      .rise   (rise[i])
    );
  end

  // Only the edge pulses drive commands; the levels are not needed here.
  assign unused_stable = ^stable_lvl;

  dir_t          mem_q [QUEUE_DEPTH];
  dir_t          mem_d [QUEUE_DEPTH];
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  dir_t          dir_q, dir_d;
  logic          dir_upd_q, dir_upd_d;
  logic          drop_q, drop_d;

  logic          cmd_vld;
  dir_t          cmd;
  dir_t          ref_dir;
  logic [PW-1:0] tail_idx;
  logic          pass, full, pop, push;

  function automatic logic [PW-1:0] next_ptr(input logic [PW-1:0] p);
    return (p == LAST) ? '0 : p + PW'(1);
  endfunction

  always_comb begin
    cmd_vld = |rise;
    if (rise[3])      cmd = UP;
    else if (rise[2]) cmd = DOWN;
    else if (rise[1]) cmd = LEFT;
    else              cmd = RIGHT;
  end

  always_comb begin
    tail_idx = (wr_ptr_q == '0) ? LAST : wr_ptr_q - PW'(1);
    // Compare against what the snake will be doing once the queue drains,
    // i.e. the last queued command, or the live direction if nothing is queued.
    ref_dir  = (count_q != '0) ? mem_q[tail_idx] : dir_q;
    pass     = cmd_vld && (cmd != ref_dir) && (cmd != opposite(ref_dir));
    full     = (count_q == CW'(QUEUE_DEPTH));
    pop      = bus.listen && (count_q != '0);
    // A pop in the same cycle frees the slot, so a full queue still accepts.
    push     = pass && (!full || pop);

    mem_d     = mem_q;
    wr_ptr_d  = wr_ptr_q;
    rd_ptr_d  = rd_ptr_q;
    count_d   = count_q;
    dir_d     = dir_q;
    dir_upd_d = pop;
    drop_d    = pass && full && !pop;

    if (push) begin
      mem_d[wr_ptr_q] = cmd;
      wr_ptr_d        = next_ptr(wr_ptr_q);
    end
    if (pop) begin
      dir_d    = mem_q[rd_ptr_q];
      rd_ptr_d = next_ptr(rd_ptr_q);
    end
    if (push && !pop)      count_d = count_q + CW'(1);
    else if (pop && !push) count_d = count_q - CW'(1);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < QUEUE_DEPTH; i++) mem_q[i] <= UP;
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      count_q   <= '0;
      dir_q     <= dir_t'(2'(RESET_DIR));
      dir_upd_q <= 1'b0;
      drop_q    <= 1'b0;
    end else begin
      mem_q     <= mem_d;
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      count_q   <= count_d;
      dir_q     <= dir_d;
      dir_upd_q <= dir_upd_d;
      drop_q    <= drop_d;
    end
  end

  assign bus.dir     = dir_q;
  assign bus.dir_upd = dir_upd_q;
  assign bus.q_count = count_q;
  assign bus.drop    = drop_q;

endmodule

// File: tb/tb_snake_dir_ctrl.sv
// Bench for snake_dir_ctrl with DEBOUNCE_CYCLES=4, QUEUE_DEPTH=2, RESET_DIR=RIGHT.
// Press table plus hand sequences; expected directions queue up and are matched on each dir_upd.
// Drives after posedge+1, monitors dir_upd/drop on negedge.
module tb_snake_dir_ctrl;
  import snake_pkg::*;

  localparam int DB = 4;
  localparam int QD = 2;

  logic clk = 1'b0;
  logic rst = 1'b1;

  always #5 clk = ~clk;

  snake_dir_ctrl_if #(.QUEUE_DEPTH(QD)) bus ();

  snake_dir_ctrl #(
    .DEBOUNCE_CYCLES (DB),
    .QUEUE_DEPTH     (QD),
    .RESET_DIR       (3)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int   checks   = 0;
  int   failures = 0;
  int   drop_cnt = 0;
  int   upd_cnt  = 0;
  dir_t sb [$];

  function automatic void check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endfunction

  // Scoreboard side: every dir update must match the oldest expected command.
  always @(negedge clk) begin
    if (rst) begin
      if (bus.drop) drop_cnt++;
      if (bus.dir_upd) begin
        upd_cnt++;
        if (sb.size() == 0) begin
          check("unexpected_dir_upd", 1, 0);
        end else begin
          dir_t e;
          e = sb.pop_front();
          check("pop_dir", int'(bus.dir), int'(e));
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_btn(input logic [3:0] m);
    bus.up    = m[3];
    bus.down  = m[2];
    bus.left  = m[1];
    bus.right = m[0];
  endtask

  // Press and release; optionally strobe listen on the edge that consumes the rise pulse.
  task automatic press(input logic [3:0] m, input bit with_listen);
    set_btn(m);
    repeat (DB) tick();
    if (with_listen) bus.listen = 1'b1;
    tick();
    bus.listen = 1'b0;
    repeat (2) tick();
    set_btn(4'b0000);
    repeat (DB + 3) tick();
  endtask

  task automatic do_listen();
    bus.listen = 1'b1;
    tick();
    bus.listen = 1'b0;
    tick();
  endtask

  task automatic do_reset();
    rst = 1'b0;
    #1;
    sb.delete();
    tick();
    rst = 1'b1;
    tick();
  endtask

  typedef struct {
    logic [3:0] btn;
    int         exp_q;
    int         exp_drops;
    bit         enq;
    dir_t       enq_dir;
  } vec_t;

  vec_t vecs [5];

  initial begin
    // Starting from dir=RIGHT: LEFT is the reversal, RIGHT the duplicate,
    // UP and LEFT fill the queue, DOWN then hits a full queue.
    vecs[0] = '{4'b0010, 0, 0, 1'b0, UP};
    vecs[1] = '{4'b0001, 0, 0, 1'b0, UP};
    vecs[2] = '{4'b1000, 1, 0, 1'b1, UP};
    vecs[3] = '{4'b0010, 2, 0, 1'b1, LEFT};
    vecs[4] = '{4'b0100, 2, 1, 1'b0, UP};

    set_btn(4'b0000);
    bus.listen = 1'b0;

    // Reset state
    #3 rst = 1'b0;
    #1;
    check("rst_dir", int'(bus.dir), 3);
    check("rst_q_count", int'(bus.q_count), 0);
    check("rst_dir_upd", int'(bus.dir_upd), 0);
    check("rst_drop", int'(bus.drop), 0);
    tick();
    rst = 1'b1;
    tick();

    // Filtering, queueing, full-queue drop
    for (int i = 0; i < 5; i++) begin
      if (vecs[i].enq) sb.push_back(vecs[i].enq_dir);
      press(vecs[i].btn, 1'b0);
      check($sformatf("vec%0d_q_count", i), int'(bus.q_count), vecs[i].exp_q);
      check($sformatf("vec%0d_drops", i), drop_cnt, vecs[i].exp_drops);
    end

    // Drain: UP then LEFT
    do_listen();
    check("pop1_q_count", int'(bus.q_count), 1);
    check("pop1_dir", int'(bus.dir), int'(UP));
    do_listen();
    check("pop2_q_count", int'(bus.q_count), 0);
    check("pop2_dir", int'(bus.dir), int'(LEFT));
    do_listen();
    check("empty_listen_dir", int'(bus.dir), int'(LEFT));
    check("empty_listen_upd_cnt", upd_cnt, 2);

    // Fill again, then reset mid-run
    sb.push_back(UP);
    press(4'b1000, 1'b0);
    sb.push_back(RIGHT);
    press(4'b0001, 1'b0);
    check("prefill_q_count", int'(bus.q_count), 2);
    rst = 1'b0;
    #1;
    check("midrst_dir", int'(bus.dir), 3);
    check("midrst_q_count", int'(bus.q_count), 0);
    check("midrst_dir_upd", int'(bus.dir_upd), 0);
    check("midrst_drop", int'(bus.drop), 0);
    sb.delete();
    tick();
    rst = 1'b1;
    tick();

    // Full [UP,LEFT]; DOWN edge arrives with listen: pop UP, push DOWN
    sb.push_back(UP);
    press(4'b1000, 1'b0);
    sb.push_back(LEFT);
    press(4'b0010, 1'b0);
    check("full_q_count", int'(bus.q_count), 2);
    sb.push_back(DOWN);
    press(4'b0100, 1'b1);
    check("pushpop_dir", int'(bus.dir), int'(UP));
    check("pushpop_q_count", int'(bus.q_count), 2);
    check("pushpop_drops", drop_cnt, 1);
    do_listen();
    do_listen();
    check("pushpop_drain_dir", int'(bus.dir), int'(DOWN));
    check("pushpop_drain_q", int'(bus.q_count), 0);

    // Simultaneous UP+LEFT from dir=RIGHT: only UP
    do_reset();
    sb.push_back(UP);
    press(4'b1010, 1'b0);
    check("simul_q_count", int'(bus.q_count), 1);
    do_listen();
    check("simul_dir", int'(bus.dir), int'(UP));
    check("simul_q_after", int'(bus.q_count), 0);

    // Bounce on up, then hold
    do_reset();
    for (int c = 0; c < 20; c++) begin
      bus.up = ((c % 4) < 2);
      tick();
      check("bounce_q_count", int'(bus.q_count), 0);
    end
    sb.push_back(UP);
    bus.up = 1'b1;
    repeat (DB) tick();
    check("hold_before_push", int'(bus.q_count), 0);
    tick();
    check("hold_push", int'(bus.q_count), 1);
    repeat (20) tick();
    check("hold_single_cmd", int'(bus.q_count), 1);
    bus.up = 1'b0;
    repeat (DB + 2) tick();
    do_listen();
    check("hold_dir", int'(bus.dir), int'(UP));

    check("total_upd", upd_cnt, 7);
    check("total_drops", drop_cnt, 1);
    check("sb_empty", sb.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
